spike_rate_decoder: RTL and testbench
=====================================

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 The block SHALL have parameter WIN_LOG2, default 8, legal range 1..16: window length N = 2^WIN_LOG2 cycles.
REQ-002 The block SHALL have parameter RATE_W, default 16: output word width.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: begin one measurement window.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous abort to IDLE.
REQ-007 The block SHALL have port spike_in, input, 1 bit: spike train under measurement.
REQ-008 The block SHALL have port rate, output, RATE_W bits: decoded rate.
REQ-009 The block SHALL have port rate_valid, output, 1 bit: rate holds a completed result.
REQ-010 The block SHALL have port rate_ready, input, 1 bit: consumer accepts rate.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in COUNT.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, COUNT and DONE.
REQ-013 In IDLE, start=1 at an edge SHALL transition the FSM to COUNT, clear the window counter and clear the spike counter.
REQ-014 In COUNT, each rising edge SHALL add spike_in to spike_cnt and increment win_cnt; exactly N edges SHALL be sampled per window.
REQ-015 On the Nth COUNT edge, the FSM SHALL go to DONE and load rate with the final count, including that edge's spike.
REQ-016 Scaling SHALL be rate = final_cnt << (RATE_W - WIN_LOG2); if final_cnt equals N, rate SHALL saturate to all-ones.
REQ-017 spike_cnt SHALL be WIN_LOG2+1 bits wide and SHALL never wrap.
REQ-018 rate_valid SHALL be high exactly while the FSM is in DONE; rate SHALL remain stable while rate_valid=1.
REQ-019 In DONE, rate_valid & rate_ready at an edge SHALL complete the handshake and leave DONE; rate SHALL keep its last value afterwards.
REQ-020 Latency SHALL be: start sampled at edge E, rate_valid high after edge E+N.
REQ-021 start SHALL be ignored in COUNT and DONE.
REQ-022 clear SHALL have priority over all other inputs: next state IDLE, counters zeroed, rate unchanged, and rate_valid low on the following cycle.
REQ-023 busy SHALL be high exactly while the FSM is in COUNT.

Reset
REQ-024 rst low SHALL immediately force: state IDLE, win_cnt=0, spike_cnt=0, rate=0, rate_valid=0, busy=0.
REQ-025 Reset mid-window SHALL discard the partial count with no result emitted; operation resumes only on a new start after rst is released.

Configuration
REQ-026 Macro SPIKE_RATE_DEC_CONT_EN SHALL select continuous mode.
REQ-027 With SPIKE_RATE_DEC_CONT_EN defined, a DONE handshake SHALL go directly to COUNT with counters cleared; the first window still requires start, and clear still returns to IDLE.
REQ-028 With SPIKE_RATE_DEC_CONT_EN defined, spikes arriving while in DONE SHALL not be counted.
REQ-029 Without SPIKE_RATE_DEC_CONT_EN, a DONE handshake SHALL return to IDLE.

Structure
REQ-030 Shared package snn_pkg SHALL hold the state enum type rate_dec_state_t (IDLE, COUNT, DONE) and constant SNN_RATE_W=16, used as the RATE_W default.
REQ-031 The block SHALL be a single module with no sub-modules; the counters and FSM are local.

Verification
REQ-032 WIN_LOG2=4, start, spike_in held 1 for 16 cycles -> rate=16'hFFFF, rate_valid rises at E+16.
REQ-033 WIN_LOG2=4, spike_in held 0 -> rate=16'h0000, rate_valid=1.
REQ-034 WIN_LOG2=4, spike_in alternating 1,0 starting with 1 -> count 8 -> rate=16'h8000; 3 spikes only -> rate=16'h3000.
REQ-035 rate_ready held low 5 cycles after rate_valid -> rate and rate_valid stable; handshake on the 6th cycle -> IDLE next cycle, or COUNT next cycle with SPIKE_RATE_DEC_CONT_EN.
REQ-036 clear asserted, or rst pulsed low, at win_cnt=7 -> IDLE, no rate_valid, rate keeps its previous value (rst: rate=0); a following start yields a full 16-cycle window.
REQ-037 start pulsed during COUNT and during DONE -> ignored, window length unchanged at 16.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-network decoder blocks.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } rate_dec_state_t;

    localparam int SNN_RATE_W = 16;

endpackage

// File: rtl/spike_rate_decoder.sv
// Counts spikes over a 2^WIN_LOG2-cycle window and emits a scaled rate word with a valid/ready handshake.
// Optional macro SPIKE_RATE_DEC_CONT_EN: after a handshake, restart the next window immediately.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int WIN_LOG2 = 8,
    parameter int RATE_W   = SNN_RATE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic              spike_in,
    output logic [RATE_W-1:0] rate,
    output logic              rate_valid,
    input  logic              rate_ready,
    output logic              busy
);

    localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;
    localparam logic [WIN_LOG2:0]   CNT_FULL = {1'b1, {WIN_LOG2{1'b0}}};

    rate_dec_state_t     state;
    rate_dec_state_t     state_next;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [WIN_LOG2:0]   spike_cnt;
    logic [WIN_LOG2:0]   final_cnt;
    logic [RATE_W-1:0]   scaled;
    logic                window_end;

    // The last edge's spike is folded in combinationally so it lands in the result.
    assign final_cnt  = spike_cnt + {{WIN_LOG2{1'b0}}, spike_in};
    assign window_end = (state == COUNT) && (win_cnt == WIN_LAST);

    // A full-window count would overflow the shifted word, so it saturates instead.
    always_comb begin
        scaled = '0;
        if (final_cnt == CNT_FULL) begin
            scaled = '1;
        end else begin
            scaled = RATE_W'(final_cnt) << (RATE_W - WIN_LOG2);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COUNT;
            COUNT:   if (win_cnt == WIN_LAST) state_next = DONE;
            DONE: begin
                if (rate_ready) begin
`ifdef SPIKE_RATE_DEC_CONT_EN
                    state_next = COUNT;
`else
                    state_next = IDLE;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        busy       = (state == COUNT);
        rate_valid = (state == DONE);
    end

    // Counters sit at zero outside COUNT, so every entry into COUNT starts a clean window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt   <= '0;
            spike_cnt <= '0;
            rate      <= '0;
        end else if (clear) begin
            win_cnt   <= '0;
            spike_cnt <= '0;
        end else if (state == COUNT) begin
            win_cnt   <= win_cnt + 1'b1;
            spike_cnt <= final_cnt;
            if (window_end) begin
                win_cnt   <= '0;
                spike_cnt <= '0;
                rate      <= scaled;
            end
        end else begin
            win_cnt   <= '0;
            spike_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed self-checking bench for spike_rate_decoder with a 16-cycle window.
module tb_spike_rate_decoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic        clear;
    logic        spike_in;
    logic [15:0] rate;
    logic        rate_valid;
    logic        rate_ready;
    logic        busy;

    int checks;
    int errors;

    spike_rate_decoder #(.WIN_LOG2(4), .RATE_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .clear      (clear),
        .spike_in   (spike_in),
        .rate       (rate),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one window: start at edge E, pat[i] drives COUNT edge E+1+i; poke pulses start mid-window.
    task automatic measure(input logic [15:0] pat, input logic [15:0] exp_rate, input int poke);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            spike_in = pat[i];
            start    = (i == poke);
            checks++;
            if (rate_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL window_len pat=%h i=%0d valid=%b busy=%b required valid=0 busy=1",
                         pat, i, rate_valid, busy);
            end
            tick();
        end
        start    = 1'b0;
        spike_in = 1'b0;
        checks++;
        if (rate_valid !== 1'b1 || busy !== 1'b0 || rate !== exp_rate) begin
            errors++;
            $display("FAIL result pat=%h valid=%b busy=%b rate=%h required valid=1 busy=0 rate=%h",
                     pat, rate_valid, busy, rate, exp_rate);
        end
        $display("window pat=%h rate=%h valid=%b", pat, rate, rate_valid);
    endtask

    // Completes the handshake and leaves the block in IDLE for the next test.
    task automatic handshake(input logic [15:0] exp_rate);
        rate_ready = 1'b1;
        tick();
        rate_ready = 1'b0;
        checks++;
`ifdef SPIKE_RATE_DEC_CONT_EN
        if (rate_valid !== 1'b0 || busy !== 1'b1 || rate !== exp_rate) begin
            errors++;
            $display("FAIL handshake valid=%b busy=%b rate=%h required valid=0 busy=1 rate=%h",
                     rate_valid, busy, rate, exp_rate);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
`else
        if (rate_valid !== 1'b0 || busy !== 1'b0 || rate !== exp_rate) begin
            errors++;
            $display("FAIL handshake valid=%b busy=%b rate=%h required valid=0 busy=0 rate=%h",
                     rate_valid, busy, rate, exp_rate);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #2;
        checks++;
        if (rate !== 16'h0000 || rate_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset rate=%h valid=%b busy=%b required rate=0000 valid=0 busy=0",
                     rate, rate_valid, busy);
        end
        tick();
        tick();
        #3 rst = 1'b1;
        tick();
        checks++;
        if (rate_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset valid=%b busy=%b required valid=0 busy=0", rate_valid, busy);
        end
        $display("reset rate=%h valid=%b busy=%b", rate, rate_valid, busy);
    endtask

    task automatic test_rates();
        measure(16'hFFFF, 16'hFFFF, -1);
        handshake(16'hFFFF);
        measure(16'h0000, 16'h0000, -1);
        handshake(16'h0000);
        measure(16'h5555, 16'h8000, -1);
        handshake(16'h8000);
        measure(16'h0007, 16'h3000, -1);
        handshake(16'h3000);
        measure(16'h7FFF, 16'hF000, -1);
        handshake(16'hF000);
        measure(16'h8000, 16'h1000, -1);
        handshake(16'h1000);
    endtask

    task automatic test_hold();
        measure(16'h0001, 16'h1000, -1);
        for (int k = 0; k < 5; k++) begin
            rate_ready = 1'b0;
            spike_in   = 1'b1;
            tick();
            checks++;
            if (rate_valid !== 1'b1 || rate !== 16'h1000) begin
                errors++;
                $display("FAIL hold k=%0d valid=%b rate=%h required valid=1 rate=1000", k, rate_valid, rate);
            end
        end
        rate_ready = 1'b1;
        tick();
        rate_ready = 1'b0;
        spike_in   = 1'b0;
        checks++;
`ifdef SPIKE_RATE_DEC_CONT_EN
        if (rate_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_exit valid=%b busy=%b required valid=0 busy=1", rate_valid, busy);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rate_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL cont_window i=%0d valid=%b busy=%b required valid=0 busy=1", i, rate_valid, busy);
            end
            tick();
        end
        checks++;
        if (rate_valid !== 1'b1 || rate !== 16'h0000) begin
            errors++;
            $display("FAIL cont_result valid=%b rate=%h required valid=1 rate=0000", rate_valid, rate);
        end
        handshake(16'h0000);
`else
        if (rate_valid !== 1'b0 || busy !== 1'b0 || rate !== 16'h1000) begin
            errors++;
            $display("FAIL hold_exit valid=%b busy=%b rate=%h required valid=0 busy=0 rate=1000",
                     rate_valid, busy, rate);
        end
`endif
        $display("hold rate=%h valid=%b busy=%b", rate, rate_valid, busy);
    endtask

    task automatic run_partial();
        start = 1'b1;
        tick();
        start    = 1'b0;
        spike_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
    endtask

    task automatic idle_quiet(input string tag, input logic [15:0] exp_rate);
        spike_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        checks++;
        if (rate_valid !== 1'b0 || busy !== 1'b0 || rate !== exp_rate) begin
            errors++;
            $display("FAIL %s_quiet valid=%b busy=%b rate=%h required valid=0 busy=0 rate=%h",
                     tag, rate_valid, busy, rate, exp_rate);
        end
    endtask

    task automatic test_clear();
        measure(16'h0007, 16'h3000, -1);
        handshake(16'h3000);
        run_partial();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (rate_valid !== 1'b0 || busy !== 1'b0 || rate !== 16'h3000) begin
            errors++;
            $display("FAIL clear valid=%b busy=%b rate=%h required valid=0 busy=0 rate=3000",
                     rate_valid, busy, rate);
        end
        idle_quiet("clear", 16'h3000);
        measure(16'h00FF, 16'h8000, -1);
        handshake(16'h8000);
        $display("clear rate=%h valid=%b busy=%b", rate, rate_valid, busy);
    endtask

    task automatic test_rst_mid();
        run_partial();
        rst = 1'b0;
        #1;
        checks++;
        if (rate !== 16'h0000 || rate_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_rst rate=%h valid=%b busy=%b required rate=0000 valid=0 busy=0",
                     rate, rate_valid, busy);
        end
        #2 rst = 1'b1;
        idle_quiet("rst", 16'h0000);
        measure(16'h000F, 16'h4000, -1);
        handshake(16'h4000);
        $display("rst_mid rate=%h valid=%b busy=%b", rate, rate_valid, busy);
    endtask

    task automatic test_start_ignored();
        measure(16'h0003, 16'h2000, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (rate_valid !== 1'b1 || busy !== 1'b0 || rate !== 16'h2000) begin
            errors++;
            $display("FAIL start_in_done valid=%b busy=%b rate=%h required valid=1 busy=0 rate=2000",
                     rate_valid, busy, rate);
        end
        handshake(16'h2000);
        $display("start_ignored rate=%h valid=%b busy=%b", rate, rate_valid, busy);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        start      = 1'b0;
        clear      = 1'b0;
        spike_in   = 1'b0;
        rate_ready = 1'b0;
        test_reset();
        test_rates();
        test_hold();
        test_clear();
        test_rst_mid();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
